// File: rtl/spi_ctrl_master.sv
// SPI mode-0 initiator: one 16-bit MSB-first frame {rw, addr, wdata} per accepted request.
// Optional readback of the data byte from cipo is enabled by defining SPI_CTRL_READBACK_EN.
module spi_ctrl_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   input  logic       cipo,
   output logic       ready,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       sclk,
   output logic       copi,
   output logic       cs_n
);

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
   localparam logic [7:0] DIV_M2 = 8'(CLK_DIV - 2);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_END   = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   state_t      state_r;
   logic [15:0] shift_r;
   logic [4:0]  bit_cnt_r;
   logic [7:0]  div_cnt_r;
   logic        div_end_s;

   assign div_end_s = (div_cnt_r == DIV_M1);

`ifdef SPI_CTRL_READBACK_EN
   logic [7:0] cap_r;
`else
   logic unused_cipo;
   assign unused_cipo = cipo;
   assign rd_data     = 8'h00;
`endif

   // Frame sequencer; every SPI pin and status output is a register driven from here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         shift_r   <= 16'h0000;
         bit_cnt_r <= 5'd0;
         div_cnt_r <= 8'd0;
         ready     <= 1'b1;
         done      <= 1'b0;
         sclk      <= 1'b0;
         copi      <= 1'b0;
         cs_n      <= 1'b1;
`ifdef SPI_CTRL_READBACK_EN
         cap_r     <= 8'h00;
         rd_data   <= 8'h00;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shift_r   <= {rw, addr, wdata};
                  copi      <= rw;
                  cs_n      <= 1'b0;
                  sclk      <= 1'b0;
                  ready     <= 1'b0;
                  div_cnt_r <= 8'd0;
                  bit_cnt_r <= 5'd0;
                  state_r   <= ST_SETUP;
               end else begin
                  ready <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (div_end_s) begin
                  div_cnt_r <= 8'd0;
                  sclk      <= 1'b1;
                  state_r   <= ST_SHIFT;
               end else begin
                  div_cnt_r <= div_cnt_r + 8'd1;
               end
            end
            ST_SHIFT: begin
               if (!div_end_s) begin
                  div_cnt_r <= div_cnt_r + 8'd1;
               end else begin
                  div_cnt_r <= 8'd0;
                  if (sclk) begin
                     // Falling edge: advance to the next bit, park copi low after the last one.
                     sclk    <= 1'b0;
                     shift_r <= {shift_r[14:0], 1'b0};
                     copi    <= (bit_cnt_r == 5'd15) ? 1'b0 : shift_r[14];
                  end else if (bit_cnt_r == 5'd15) begin
                     cs_n    <= 1'b1;
                     done    <= 1'b1;
                     state_r <= ST_END;
`ifdef SPI_CTRL_READBACK_EN
                     rd_data <= cap_r;
`endif
                  end else begin
                     sclk      <= 1'b1;
                     bit_cnt_r <= bit_cnt_r + 5'd1;
`ifdef SPI_CTRL_READBACK_EN
                     // Rises of bits 9..16 carry the data byte.
                     if (bit_cnt_r >= 5'd7) begin
                        cap_r <= {cap_r[6:0], cipo};
                     end else begin
                        cap_r <= cap_r;
                     end
`endif
                  end
               end
            end
            ST_END: begin
               done      <= 1'b0;
               div_cnt_r <= 8'd0;
               state_r   <= ST_GAP;
            end
            ST_GAP: begin
               // END plus this state plus the first IDLE cycle keep cs_n high for CLK_DIV+1 cycles.
               if (div_cnt_r == DIV_M2) begin
                  ready     <= 1'b1;
                  div_cnt_r <= 8'd0;
                  state_r   <= ST_IDLE;
               end else begin
                  div_cnt_r <= div_cnt_r + 8'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               ready   <= 1'b1;
               done    <= 1'b0;
               sclk    <= 1'b0;
               copi    <= 1'b0;
               cs_n    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ctrl_master.sv
// Directed bench for spi_ctrl_master: frame content, timing, back-to-back, busy, reset and readback.
module tb_spi_ctrl_master;

`ifdef SPI_CTRL_READBACK_EN
   localparam logic [7:0] RB_EXP = 8'h5A;
`else
   localparam logic [7:0] RB_EXP = 8'h00;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start2 = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = 7'd0;
   logic [7:0] wdata = 8'd0;
   logic       cipo = 1'b0;
   logic       ready, done, sclk, copi, cs_n;
   logic [7:0] rd_data;
   logic       ready2, done2, sclk2, copi2, cs_n2;
   logic [7:0] rd_data2;

   spi_ctrl_master #(.CLK_DIV(4)) dut (
      .clk(clk), .rst(rst), .start(start), .rw(rw), .addr(addr), .wdata(wdata), .cipo(cipo),
      .ready(ready), .done(done), .rd_data(rd_data), .sclk(sclk), .copi(copi), .cs_n(cs_n)
   );

   spi_ctrl_master #(.CLK_DIV(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .rw(rw), .addr(addr), .wdata(wdata), .cipo(cipo),
      .ready(ready2), .done(done2), .rd_data(rd_data2), .sclk(sclk2), .copi(copi2), .cs_n(cs_n2)
   );

   always #5 clk = ~clk;

   logic       sel = 1'b0;
   logic       m_ready, m_done, m_sclk, m_copi, m_cs_n;
   logic [7:0] m_rd;
   assign m_ready = sel ? ready2 : ready;
   assign m_done  = sel ? done2 : done;
   assign m_sclk  = sel ? sclk2 : sclk;
   assign m_copi  = sel ? copi2 : copi;
   assign m_cs_n  = sel ? cs_n2 : cs_n;
   assign m_rd    = sel ? rd_data2 : rd_data;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int t0, rises, falls, cs_low, ndone, ncsf, rise1, rise2, ready_cyc;
   int done_cyc [4];
   int csf_cyc [4];
   logic [15:0] frames [4];
   logic [15:0] cap;
   logic [7:0]  rd_at_done, rb_byte;
   logic        prev_sclk, prev_cs, prev_ready;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      rises = 0; falls = 0; cs_low = 0; ndone = 0; ncsf = 0; rise1 = 0; rise2 = 0; ready_cyc = 0;
      cap = 16'h0000; rd_at_done = 8'h00;
      for (int i = 0; i < 4; i++) begin
         done_cyc[i] = 0; csf_cyc[i] = 0; frames[i] = 16'h0000;
      end
      prev_sclk = m_sclk; prev_cs = m_cs_n; prev_ready = m_ready;
   endtask

   // One clock: sample at the falling edge, update statistics and drive cipo for readback.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (m_sclk && !prev_sclk) begin
         rises++;
         cap = {cap[14:0], m_copi};
         if (rises == 1) rise1 = cyc;
         if (rises == 2) rise2 = cyc;
      end
      if (!m_sclk && prev_sclk) begin
         falls++;
         if (falls >= 8 && falls <= 15) cipo = rb_byte[15 - falls];
         else cipo = 1'b0;
      end
      if (!m_cs_n && prev_cs) begin
         if (ncsf < 4) csf_cyc[ncsf] = cyc;
         ncsf++;
      end
      if (!m_cs_n) cs_low++;
      if (m_done) begin
         if (ndone < 4) begin
            frames[ndone] = cap; done_cyc[ndone] = cyc;
         end
         rd_at_done = m_rd;
         ndone++;
      end
      if (m_ready && !prev_ready) ready_cyc = cyc;
      prev_sclk = m_sclk; prev_cs = m_cs_n; prev_ready = m_ready;
   endtask

   task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d, input bit hold);
      for (int i = 0; i < 300 && !m_ready; i++) step();
      rw = r; addr = a; wdata = d;
      if (sel) start2 = 1'b1; else start = 1'b1;
      t0 = cyc;
      step();
      if (!hold) begin
         start = 1'b0; start2 = 1'b0;
      end
   endtask

   task automatic finish_frame(input int n);
      for (int i = 0; i < 600 && !(m_ready && ndone >= n); i++) step();
   endtask

   initial begin
      rb_byte = 8'h00;
      clr();
      // Reset state
      step(); step();
      check("rst_cs_n", cs_n, 1'b1);
      check("rst_sclk", sclk, 1'b0);
      check("rst_copi", copi, 1'b0);
      check("rst_ready", ready, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_cs_n_d2", cs_n2, 1'b1);
      rst = 1'b0;
      step();

      // Write duty cycle 0x04 <- 0x80
      clr();
      issue(1'b1, 7'h04, 8'h80, 1'b0);
      check("wr_cs_fall", csf_cyc[0] - t0, 1);
      finish_frame(1);
      check("wr_ready_back", m_ready, 1'b1);
      check("wr_frame", frames[0], 16'h8480);
      check("wr_rises", rises, 16);
      check("wr_cs_low", cs_low, 132);
      check("wr_done_cnt", ndone, 1);
      check("wr_done_at", done_cyc[0] - t0, 133);
      check("wr_ready_at", ready_cyc - t0, 137);
      check("wr_rise1_at", rise1 - t0, 5);
      check("wr_sclk_period", rise2 - rise1, 8);
      check("wr_copi_idle", m_copi, 1'b0);

      // Back-to-back 0x00 <- 0xFF then 0x02 <- 0x0F, start held high
      clr();
      issue(1'b1, 7'h00, 8'hFF, 1'b1);
      addr = 7'h02; wdata = 8'h0F;
      for (int i = 0; i < 600 && ncsf < 2; i++) step();
      start = 1'b0;
      finish_frame(2);
      for (int i = 0; i < 40; i++) step();
      check("b2b_ready_back", m_ready, 1'b1);
      check("b2b_frame0", frames[0], 16'h80FF);
      check("b2b_frame1", frames[1], 16'h820F);
      check("b2b_gap", csf_cyc[1] - done_cyc[0], 5);
      check("b2b_done_cnt", ndone, 2);
      check("b2b_frames", ncsf, 2);

      // Busy rejection
      clr();
      issue(1'b1, 7'h02, 8'h55, 1'b0);
      for (int i = 0; i < 600 && !(m_ready && ndone >= 1); i++) begin
         step();
         if (cyc == t0 + 40) begin
            start = 1'b1; addr = 7'h01;
         end else begin
            start = 1'b0;
         end
      end
      for (int i = 0; i < 40; i++) step();
      check("busy_ready_back", m_ready, 1'b1);
      check("busy_frame", frames[0], 16'h8255);
      check("busy_done_cnt", ndone, 1);
      check("busy_frames", ncsf, 1);

      // Reset mid-frame
      clr();
      issue(1'b1, 7'h05, 8'h11, 1'b0);
      for (int i = 0; i < 100 && cyc < t0 + 50; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_cs_n", m_cs_n, 1'b1);
      check("mrst_sclk", m_sclk, 1'b0);
      check("mrst_ready", m_ready, 1'b1);
      check("mrst_done", m_done, 1'b0);
      for (int i = 0; i < 150; i++) step();
      check("mrst_no_done", ndone, 0);
      clr();
      issue(1'b1, 7'h03, 8'hAA, 1'b0);
      finish_frame(1);
      check("mrst_next_ready", m_ready, 1'b1);
      check("mrst_next_frame", frames[0], 16'h83AA);
      check("mrst_next_done", ndone, 1);

      // Readback: read 0x04, peripheral returns 0x5A
      clr();
      rb_byte = 8'h5A;
      issue(1'b0, 7'h04, 8'h00, 1'b0);
      finish_frame(1);
      check("rb_ready_back", m_ready, 1'b1);
      check("rb_frame", frames[0], 16'h0400);
      check("rb_rd_at_done", rd_at_done, RB_EXP);
      step(); step();
      check("rb_rd_hold", m_rd, RB_EXP);
      rb_byte = 8'h00;

      // Minimum divider instance, write 0x01 <- 0x3C
      sel = 1'b1;
      step();
      clr();
      issue(1'b1, 7'h01, 8'h3C, 1'b0);
      finish_frame(1);
      check("d2_ready_back", m_ready, 1'b1);
      check("d2_frame", frames[0], 16'h813C);
      check("d2_cs_low", cs_low, 66);
      check("d2_sclk_period", rise2 - rise1, 4);
      check("d2_done_at", done_cyc[0] - t0, 67);
      check("d2_ready_at", ready_cyc - t0, 69);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_ctrl_master.md
# spi_ctrl_master

SPI controller (initiator) that generates `sclk`, `copi` and `cs_n` frames toward the design's SPI register peripheral. Each accepted request becomes one 16-bit, MSB-first, mode-0 frame: `{rw, addr[6:0], data[7:0]}`. It is the write side of the register bus, which configures output enables (0x00/0x01), PWM enables (0x02/0x03) and duty cycle (0x04). It is used both as the on-chip bring-up driver and as the verification driver for the peripheral.

## Interface
- `CLK_DIV`, default 4: `sclk` half-period in `clk` cycles. Legal values are 2..255; it is also the inter-frame gap.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset. One clock domain only.
- `start` in 1: request strobe. Accepted only on a cycle where `ready`=1.
- `rw` in 1: frame bit 15. 1 = write, 0 = read.
- `addr` in 7: register address, frame bits 14:8.
- `wdata` in 8: write data, frame bits 7:0.
- `cipo` in 1: peripheral data out. Used only with `SPI_CTRL_READBACK_EN`.
- `ready` out 1: idle; a new request may be accepted.
- `done` out 1: one-cycle pulse at frame completion.
- `rd_data` out 8: last 8 bits sampled from `cipo`.
- `sclk` out 1: SPI clock. Idles low.
- `copi` out 1: SPI data to the peripheral.
- `cs_n` out 1: chip select, active low.

## Operation
- **Reset values:** `cs_n`=1, `sclk`=0, `copi`=0, `ready`=1, `done`=0, `rd_data`=0x00. The FSM goes to IDLE and the counters clear.
- **IDLE.** `ready`=1. `start` && `ready` at edge t0 latches `{rw,addr,wdata}` into a 16-bit shift register, drops `ready` and goes to SETUP.
- **SETUP.**
  - `cs_n`=0, `sclk`=0 and `copi`=frame[15].
  - Hold for `CLK_DIV` cycles, then go to SHIFT.
- **SHIFT.** 16 bits, each made of:
  - a high phase of `CLK_DIV` cycles (rising edge at the start of the phase);
  - then a low phase of `CLK_DIV` cycles.
  - On each falling edge the shift register shifts left and `copi` presents the next bit.
  - After the 16th falling edge `copi` goes to 0.
  - The 16th low phase doubles as the chip-select hold time.
  - A 5-bit bit counter and an 8-bit divider counter track progress.
- **END.**
  - `cs_n`=1 and `done`=1 for exactly this one cycle.
  - Go to GAP.
- **GAP.**
  - `cs_n` stays high for `CLK_DIV` cycles.
  - `ready` reasserts on the cycle after the gap ends.
- **Busy and back-to-back requests.**
  - `start` while `ready`=0 is ignored, not queued.
  - Inputs may change freely after acceptance.
  - The earliest next request is accepted on the cycle `ready` returns, which gives back-to-back frames with the minimum gap.
- **Reset mid-frame.** Outputs return to reset values on the next edge. `cs_n` rises with no `done`, and the partial frame is discarded.
- **Glitch-free outputs.** `sclk`, `copi` and `cs_n` are all registers, never combinational.

## Timing
- Cycle numbering is relative to the accept edge t0, with D = `CLK_DIV`.
- `cs_n` falls at t0+1.
- The first `sclk` rise is at t0+1+D.
- The k-th rise (k=1..16) is at t0+1+(2k−1)D. The k-th fall is at t0+1+2kD.
- `cs_n` rises and `done` pulses at t0+1+33D.
- `ready`=1 at t0+1+34D.
- With D=4: `cs_n` is low for 132 cycles, `done` pulses at t0+133 and `ready` returns at t0+137.
- `copi` is stable for at least D cycles on both sides of every rising `sclk` edge.

## Configuration
- **`SPI_CTRL_READBACK_EN` defined:**
  - `cipo` is registered on each `sclk` rising edge of bits 9..16 (the data byte) into `rd_data`, MSB first.
  - `rd_data` updates in the END cycle and holds until the next END or reset.
  - Capture happens for both read and write frames.
- **`SPI_CTRL_READBACK_EN` undefined:**
  - No capture logic; `rd_data` is tied to 0x00.
  - `cipo` is unused and is listed in the unused-signal sink.
  - All other behaviour is identical.

## Test plan
- **Write duty cycle.** Reset, then `rw`=1, `addr`=0x04, `wdata`=0x80, D=4.
  - Bits sampled on `copi` at 16 `sclk` rises = 0x8480.
  - `cs_n` is low exactly 132 cycles.
  - `done` is a single pulse at t0+133.
  - `ready` returns at t0+137.
- **Back-to-back writes.** 0x00←0xFF, then 0x02←0x0F with `start` held high continuously.
  - Two frames, 0x80FF then 0x820F.
  - `cs_n` high exactly D+1 cycles between frames (END + GAP).
  - Exactly two `done` pulses.
- **Busy rejection.** Pulse `start` with `addr`=0x01 at t0+40 of an active frame.
  - The frame in progress is unchanged.
  - No second frame occurs.
  - Exactly one `done`.
- **Reset mid-frame.** Assert `rst` at t0+50 for 1 cycle.
  - Next edge: `cs_n`=1, `sclk`=0, `ready`=1.
  - No `done`.
  - A following write 0x03←0xAA completes normally as 0x83AA.
- **Readback (macro defined).** Read frame with `rw`=0, `addr`=0x04; the bench drives `cipo`=0x5A MSB-first, changing on falling edges from bit 9.
  - `rd_data`=0x5A at `done`.
  - With the macro undefined, `rd_data` stays 0x00.
- **Minimum divider.** `CLK_DIV`=2, write 0x01←0x3C.
  - Frame 0x813C.
  - `cs_n` low 66 cycles; `sclk` period 4 cycles.
